// File: rtl/sensor_sched_pkg.sv
// Shared types and default timing for the two-sensor ultrasonic scheduler.
// Default constants assume a 100 MHz clock.
package sensor_sched_pkg;

    typedef enum logic [2:0] {
        IDLE,
        TRIG,
        WAIT_RISE,
        MEASURE,
        GUARD
    } state_t;

    typedef enum logic {
        SENS_A = 1'b0,
        SENS_B = 1'b1
    } sens_t;

    localparam int DEF_TRIG_CYCLES    = 1000;
    localparam int DEF_CM_CYCLES      = 5800;
    localparam int DEF_TIMEOUT_CYCLES = 3_000_000;
    localparam int DEF_GUARD_CYCLES   = 1_000_000;
    localparam int DEF_DIST_W         = 8;

endpackage

// File: rtl/echo_meter.sv
// Echo pulse-width meter: 2-FF synchroniser, centimetre prescaler,
// saturating distance counter and a timeout timer armed by start.
module echo_meter #(
    parameter int CM_CYCLES      = 5800,
    parameter int TIMEOUT_CYCLES = 3_000_000,
    parameter int DIST_W         = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              echo,
    input  logic              start,
    output logic              done,
    output logic              timed_out,
    output logic              measuring,
    output logic [DIST_W-1:0] distance
);

    localparam int PW = (CM_CYCLES > 1) ? $clog2(CM_CYCLES) : 1;
    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic          echo_s1;
    logic          echo_s2;
    logic          echo_d;
    logic          active;
    logic [PW-1:0] presc;
    logic [TW-1:0] timer;
    logic          rise;
    logic          fall;

    // Edges are taken after the synchroniser, so a level already high at arm time never counts as a rise.
    assign rise = echo_s2 & ~echo_d;
    assign fall = ~echo_s2 & echo_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            echo_s1   <= 1'b0;
            echo_s2   <= 1'b0;
            echo_d    <= 1'b0;
            active    <= 1'b0;
            measuring <= 1'b0;
            done      <= 1'b0;
            timed_out <= 1'b0;
            presc     <= '0;
            timer     <= '0;
            distance  <= '0;
        end else begin
            echo_s1   <= echo;
            echo_s2   <= echo_s1;
            echo_d    <= echo_s2;
            done      <= 1'b0;
            timed_out <= 1'b0;
            if (start) begin
                active    <= 1'b1;
                measuring <= 1'b0;
                timer     <= '0;
            end else if (active) begin
                if (timer == TW'(TIMEOUT_CYCLES - 1)) begin
                    timed_out <= 1'b1;
                    active    <= 1'b0;
                    measuring <= 1'b0;
                    distance  <= '1;
                end else begin
                    timer <= timer + 1'b1;
                    if (!measuring) begin
                        // The rising cycle is itself the first high cycle of the pulse.
                        if (rise) begin
                            measuring <= 1'b1;
                            if (CM_CYCLES == 1) begin
                                presc    <= '0;
                                distance <= DIST_W'(1);
                            end else begin
                                presc    <= PW'(1);
                                distance <= '0;
                            end
                        end
                    end else if (fall) begin
                        done      <= 1'b1;
                        active    <= 1'b0;
                        measuring <= 1'b0;
                    end else if (presc == PW'(CM_CYCLES - 1)) begin
                        presc <= '0;
                        if (distance != '1)
                            distance <= distance + 1'b1;
                    end else begin
                        presc <= presc + 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: rtl/sensor_scheduler.sv
// Alternates two ultrasonic rangers (A then B) and publishes both distances per round.
// Optional build macro SENSOR_SCHED_HOLD_LAST_EN: a timeout keeps the previous good distance.
module sensor_scheduler
    import sensor_sched_pkg::*;
#(
    parameter int TRIG_CYCLES    = DEF_TRIG_CYCLES,
    parameter int CM_CYCLES      = DEF_CM_CYCLES,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
    parameter int GUARD_CYCLES   = DEF_GUARD_CYCLES,
    parameter int DIST_W         = DEF_DIST_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic              echo_a,
    input  logic              echo_b,
    output logic              trig_a,
    output logic              trig_b,
    output logic [DIST_W-1:0] dist_a,
    output logic [DIST_W-1:0] dist_b,
    output logic [1:0]        err,
    output logic              valid,
    output logic              busy
);

    localparam int TCW = (TRIG_CYCLES > 1) ? $clog2(TRIG_CYCLES) : 1;
    localparam int GW  = (GUARD_CYCLES > 1) ? $clog2(GUARD_CYCLES) : 1;

    state_t            state;
    sens_t             sel;
    logic [TCW-1:0]    trig_cnt;
    logic [GW-1:0]     guard_cnt;
    logic [DIST_W-1:0] shadow_a;
    logic [DIST_W-1:0] shadow_b;
    logic [1:0]        err_shadow;
    logic              meter_start;
    logic              meter_done;
    logic              meter_timed_out;
    logic              meter_measuring;
    logic [DIST_W-1:0] meter_distance;
    logic              echo_sel;

    assign echo_sel = (sel == SENS_A) ? echo_a : echo_b;

    echo_meter #(
        .CM_CYCLES      (CM_CYCLES),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .DIST_W         (DIST_W)
    ) u_meter (
        .clk       (clk),
        .rst       (rst),
        .echo      (echo_sel),
        .start     (meter_start),
        .done      (meter_done),
        .timed_out (meter_timed_out),
        .measuring (meter_measuring),
        .distance  (meter_distance)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            sel         <= SENS_A;
            trig_cnt    <= '0;
            guard_cnt   <= '0;
            shadow_a    <= '0;
            shadow_b    <= '0;
            err_shadow  <= '0;
            meter_start <= 1'b0;
            trig_a      <= 1'b0;
            trig_b      <= 1'b0;
            dist_a      <= '0;
            dist_b      <= '0;
            err         <= '0;
            valid       <= 1'b0;
            busy        <= 1'b0;
        end else begin
            valid       <= 1'b0;
            meter_start <= 1'b0;
            case (state)
                IDLE: begin
                    if (enable) begin
                        state    <= TRIG;
                        trig_cnt <= '0;
                        trig_a   <= 1'b1;
                        busy     <= 1'b1;
                    end
                end
                TRIG: begin
                    if (trig_cnt == TCW'(TRIG_CYCLES - 1)) begin
                        trig_a      <= 1'b0;
                        trig_b      <= 1'b0;
                        meter_start <= 1'b1;
                        state       <= WAIT_RISE;
                    end else begin
                        trig_cnt <= trig_cnt + 1'b1;
                    end
                end
                WAIT_RISE, MEASURE: begin
                    // Timeout wins over a simultaneous result: a still-high echo is not a partial reading.
                    if (meter_timed_out) begin
                        if (sel == SENS_A) begin
`ifdef SENSOR_SCHED_HOLD_LAST_EN
                            shadow_a <= shadow_a;
`else
                            shadow_a <= '1;
`endif
                            err_shadow[0] <= 1'b1;
                        end else begin
`ifdef SENSOR_SCHED_HOLD_LAST_EN
                            shadow_b <= shadow_b;
`else
                            shadow_b <= '1;
`endif
                            err_shadow[1] <= 1'b1;
                        end
                        guard_cnt <= '0;
                        state     <= GUARD;
                    end else if (meter_done) begin
                        if (sel == SENS_A) begin
                            shadow_a      <= meter_distance;
                            err_shadow[0] <= 1'b0;
                        end else begin
                            shadow_b      <= meter_distance;
                            err_shadow[1] <= 1'b0;
                        end
                        guard_cnt <= '0;
                        state     <= GUARD;
                    end else if (meter_measuring) begin
                        state <= MEASURE;
                    end
                end
                GUARD: begin
                    if (guard_cnt == GW'(GUARD_CYCLES - 1)) begin
                        trig_cnt <= '0;
                        if (sel == SENS_A) begin
                            sel    <= SENS_B;
                            trig_b <= 1'b1;
                            state  <= TRIG;
                        end else begin
                            dist_a <= shadow_a;
                            dist_b <= shadow_b;
                            err    <= err_shadow;
                            valid  <= 1'b1;
                            sel    <= SENS_A;
                            if (enable) begin
                                trig_a <= 1'b1;
                                state  <= TRIG;
                            end else begin
                                busy  <= 1'b0;
                                state <= IDLE;
                            end
                        end
                    end else begin
                        guard_cnt <= guard_cnt + 1'b1;
                    end
                end
                default: begin
                    trig_a <= 1'b0;
                    trig_b <= 1'b0;
                    busy   <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

endmodule
